// File: rtl/seq_match_ctrl.sv
// Word-to-bit-serial controller for a 4-bit overlapping pattern matcher.
// Bit history carries across words unless cleared while idle.
module seq_match_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        pattern,
    input  logic [2:0]        pat_len,
    input  logic              clear_hist,
    output logic              busy,
    output logic              match,
    output logic              done,
    output logic [CNT_W-1:0]  match_count
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);

    logic [1:0]        state;
    logic [DATA_W-1:0] word;
    logic [3:0]        pat_q;
    logic [2:0]        len_q;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        hist;
    logic [2:0]        hcnt;

    logic [3:0] hist_next;
    logic [3:0] mask;
    logic [2:0] hcnt_next;
    logic [2:0] len_eff;
    logic       hit;

    // Match is judged on the history as it will look after this cycle's shift.
    always_comb begin
        len_eff   = (pat_len > 3'd4) ? 3'd4 : pat_len;
        hist_next = {hist[2:0], word[idx]};
        hcnt_next = (hcnt >= 3'd4) ? 3'd4 : hcnt + 3'd1;
        case (len_q)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            3'd3:    mask = 4'b0111;
            3'd4:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        hit = (state == SHIFT) && (len_q != 3'd0) && (hcnt_next >= len_q)
              && (((hist_next ^ pat_q) & mask) == 4'b0000);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= IDLE;
            word        <= '0;
            pat_q       <= 4'b0000;
            len_q       <= 3'd0;
            idx         <= '0;
            hist        <= 4'b0000;
            hcnt        <= 3'd0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= 1'b0;
            case (state)
                IDLE: begin
                    // Clear first so a coinciding accept starts from empty history.
                    if (clear_hist) begin
                        hist <= 4'b0000;
                        hcnt <= 3'd0;
                    end
                    if (in_valid) begin
                        word        <= in_data;
                        pat_q       <= pattern;
                        len_q       <= len_eff;
                        match_count <= '0;
                        idx         <= IDX_TOP;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    hist <= hist_next;
                    hcnt <= hcnt_next;
                    if (hit) begin
                        match <= 1'b1;
                        if (match_count != CNT_MAX)
                            match_count <= match_count + 1'b1;
                    end
                    if (idx == '0)
                        state <= DONE;
                    else
                        idx <= idx - 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state == SHIFT) || (state == DONE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl: an 8-bit instance for the functional cases
// and a 32-bit instance for counter saturation.
module tb_seq_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] pattern;
    logic [2:0] pat_len;
    logic       clear_hist;
    logic       in_ready, busy, match, done;
    logic [3:0] match_count;

    logic        s_in_valid;
    logic [31:0] s_in_data;
    logic [3:0]  s_pattern;
    logic [2:0]  s_pat_len;
    logic        s_clear_hist;
    logic        s_in_ready, s_busy, s_match, s_done;
    logic [3:0]  s_match_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_match_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .pattern(pattern), .pat_len(pat_len),
        .clear_hist(clear_hist), .busy(busy), .match(match), .done(done),
        .match_count(match_count)
    );

    seq_match_ctrl #(.DATA_W(32), .CNT_W(4)) dut32 (
        .clk(clk), .rst_(rst_), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .pattern(s_pattern), .pat_len(s_pat_len),
        .clear_hist(s_clear_hist), .busy(s_busy), .match(s_match), .done(s_done),
        .match_count(s_match_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Eight shift edges; mv[7] holds the match seen after the first shift.
    task automatic shift_phase(output logic [7:0] mv, output logic low_ok);
        mv     = 8'h00;
        low_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) low_ok = 1'b0;
            @(posedge clk); #1;
            mv[7-i] = match;
        end
    endtask

    task automatic scan8(input string tag, input logic [7:0] d, input logic [3:0] p,
                         input logic [2:0] l, input logic clr,
                         input logic [7:0] exp_mv, input logic [3:0] exp_cnt);
        logic [7:0] mv;
        logic       low_ok;
        in_valid = 1'b1; in_data = d; pattern = p; pat_len = l; clear_hist = clr;
        @(posedge clk); #1;
        in_valid = 1'b0; clear_hist = 1'b0; pattern = ~p; pat_len = 3'd4; in_data = ~d;
        shift_phase(mv, low_ok);
        check({tag, "_matches"}, mv, exp_mv);
        check({tag, "_ready_low"}, low_ok, 1'b1);
        check({tag, "_done_state"}, {done, in_ready, busy}, 3'b101);
        check({tag, "_count"}, match_count, exp_cnt);
        @(posedge clk); #1;
        check({tag, "_idle"}, {done, in_ready, busy, match_count}, {3'b010, exp_cnt});
    endtask

    initial begin
        logic [7:0] mv;
        logic       low_ok;
        logic       done_seen;
        int         pulses, done_at;
        logic [3:0] cnt14, cnt32;

        rst_ = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; pattern = 4'h0; pat_len = 3'd0; clear_hist = 1'b0;
        s_in_valid = 1'b0; s_in_data = 32'h0; s_pattern = 4'h0; s_pat_len = 3'd0; s_clear_hist = 1'b0;
        #12;
        check("reset_outputs", {in_ready, busy, match, done, match_count}, 8'b1000_0000);
        check("reset_outputs32", {s_in_ready, s_busy, s_match, s_done, s_match_count}, 8'b1000_0000);
        rst_ = 1'b1;
        @(posedge clk); #1;

        scan8("basic",   8'hB6, 4'b1011, 3'd4, 1'b0, 8'h12, 4'd2);
        scan8("carry_a", 8'h05, 4'b1011, 3'd4, 1'b0, 8'h00, 4'd0);
        scan8("carry_b", 8'h80, 4'b1011, 3'd4, 1'b0, 8'h80, 4'd1);
        scan8("clr_a",   8'h05, 4'b1011, 3'd4, 1'b0, 8'h00, 4'd0);
        scan8("clr_b",   8'h80, 4'b1011, 3'd4, 1'b1, 8'h00, 4'd0);
        scan8("short",   8'hFF, 4'b0011, 3'd2, 1'b1, 8'h7F, 4'd7);
        scan8("len0",    8'hFF, 4'b0011, 3'd0, 1'b1, 8'h00, 4'd0);
        scan8("len5",    8'hFF, 4'b1111, 3'd5, 1'b1, 8'h1F, 4'd5);
        scan8("len7",    8'hFF, 4'b1111, 3'd7, 1'b1, 8'h1F, 4'd5);
        scan8("len3",    8'hB6, 4'b0110, 3'd3, 1'b1, 8'h09, 4'd2);

        // Back-to-back with in_valid held; second word takes the pattern presented at its own accept.
        in_valid = 1'b1; in_data = 8'hB6; pattern = 4'b1011; pat_len = 3'd4; clear_hist = 1'b1;
        @(posedge clk); #1;
        clear_hist = 1'b0; pattern = 4'b0110; in_data = 8'h36;
        shift_phase(mv, low_ok);
        check("b2b_w1_matches", mv, 8'h12);
        check("b2b_w1_ready_low", low_ok, 1'b1);
        check("b2b_w1_done", {done, in_ready, busy, match_count}, {3'b101, 4'd2});
        @(posedge clk); #1;
        check("b2b_idle_gap", {done, in_ready, busy}, 3'b010);
        @(posedge clk); #1;
        check("b2b_accept2", {in_ready, busy}, 2'b01);
        in_valid = 1'b0; pattern = 4'b1011;
        shift_phase(mv, low_ok);
        check("b2b_w2_matches", mv, 8'h09);
        check("b2b_w2_done", {done, match_count}, {1'b1, 4'd2});
        @(posedge clk); #1;

        // Reset in the middle of a word.
        in_valid = 1'b1; in_data = 8'hFF; pattern = 4'b0001; pat_len = 3'd1; clear_hist = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("abort_pre", {busy, match_count}, {1'b1, 4'd3});
        rst_ = 1'b0; #1;
        check("abort_reset_vals", {in_ready, busy, match, done, match_count}, 8'b1000_0000);
        done_seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; done_seen |= done; end
        rst_ = 1'b1;
        repeat (2) begin @(posedge clk); #1; done_seen |= done; end
        check("abort_no_done", {done_seen, in_ready}, 2'b01);
        scan8("abort_empty", 8'hFF, 4'b0011, 3'd2, 1'b0, 8'h7F, 4'd7);

        // Saturation on the 32-bit instance.
        s_in_valid = 1'b1; s_in_data = 32'hFFFF_FFFF; s_pattern = 4'b0001; s_pat_len = 3'd1; s_clear_hist = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_clear_hist = 1'b0;
        pulses = 0; done_at = 0; cnt14 = 4'd0; cnt32 = 4'd0;
        for (int i = 1; i <= 34; i++) begin
            @(posedge clk); #1;
            pulses += int'(s_match);
            if (s_done && done_at == 0) done_at = i;
            if (i == 14) cnt14 = s_match_count;
            if (i == 32) cnt32 = s_match_count;
        end
        check("sat_pulses", pulses, 32);
        check("sat_count14", cnt14, 4'd14);
        check("sat_count_final", cnt32, 4'd15);
        check("sat_done_edge", done_at, 32);
        check("sat_hold_idle", {s_in_ready, s_match_count}, {1'b1, 4'd15});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Controller that feeds parallel words, MSB first, into a 4-bit serial pattern-match engine and reports matches per word. It sits between a word-oriented producer (valid/ready) and the bit-serial detection datapath. It owns bit sequencing, pattern/length configuration latching, history continuity across words, and per-word match accounting.

## Interface
- DATA_W, 8, word width in bits; legal range 2..32.
- CNT_W, 4, width of the per-word match counter.
- clk  input  1  rising-edge clock.
- rst_  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller can accept a word; high only in IDLE.
- in_data  input  DATA_W  word to scan; bit DATA_W-1 is scanned first.
- pattern  input  4  target pattern; pattern[0] matches the newest bit.
- pat_len  input  3  number of low pattern bits compared; 0 means never match; 5..7 clamp to 4.
- clear_hist  input  1  discard bit history carried over from earlier words.
- busy  output  1  high in SHIFT and DONE.
- match  output  1  one-cycle pulse per detected occurrence.
- done  output  1  one-cycle pulse at end of word.
- match_count  output  CNT_W  matches in the current or last word; saturating.

## Operation
- States: IDLE, SHIFT, DONE. Reset enters IDLE.
- Reset values: in_ready=1, busy=0, match=0, done=0, match_count=0. History register hist[3:0]=0, history fill count hcnt=0, bit index=0.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, pattern, and effective length L = min(pat_len,4). Clear match_count, set index=DATA_W-1, go to SHIFT.
- SHIFT: each cycle, hist <= {hist[2:0], word[index]} and hcnt <= min(hcnt+1,4). Decrement index. After index 0 is shifted, go to DONE.
- Match rule, evaluated on the post-shift history: L≠0, hcnt_new ≥ L, and hist_new[L-1:0]==pattern[L-1:0]. A match registers match=1 for one cycle and increments match_count, saturating at 2^CNT_W-1.
- Detection is overlapping. History is retained across words, so a pattern spanning a word boundary is detected in the later word.
- clear_hist is honored only in IDLE and sets hist=0, hcnt=0. If it coincides with an accept, the clear applies first and the new word scans from empty history. It is ignored in SHIFT and DONE.
- DONE: done=1 for exactly one cycle, and match_count holds the final value. Then go to IDLE. match_count holds until the next accept.
- pattern and pat_len changes after the accept edge have no effect on the word in flight.
- Reset mid-word aborts the word. No done pulse is produced, and all state returns to the reset values.

## Timing
- Accept at edge N. Bits are shifted at edges N+1..N+DATA_W. DONE is the cycle after edge N+DATA_W. IDLE resumes at edge N+DATA_W+1.
- A match caused by the bit shifted at edge K shows as match=1 in the cycle after K. match_count reflects it in the same cycle.
- Throughput is one word per DATA_W+2 cycles (one accept cycle, DATA_W shift cycles, one DONE cycle). in_ready=0 from edge N+1 until IDLE.
- in_ready is a function of state only and has no combinational path from in_valid.
- The final match of a word and done may be high in the same cycle. In that cycle match_count already includes that final match.

## Test plan
- Scan 8'b1011_0110 with pattern=4'b1011, pat_len=4, from reset. Required: match pulses after shift 4 and shift 7, then done with match_count=2.
- Cross-word carry: scan 8'b0000_0101 (count 0), then 8'b1000_0000. Required: match after shift 1 of the second word, count=1. Repeat with clear_hist=1 at the second accept; required count=0.
- Short pattern: pattern=4'b0011, pat_len=2, scan 8'hFF from empty history. Required: no match at shift 1, matches at shifts 2..8, count=7. With pat_len=0 or any pat_len≥5, check the pat_len rules: 0 gives count=0, 5..7 behave as 4.
- Saturation: DATA_W=32, CNT_W=4, pattern=4'b0001, pat_len=1, data 32'hFFFF_FFFF. Required: 32 match pulses, match_count stops at 15, done on cycle N+33.
- Back-to-back: hold in_valid=1 with two words. Required: in_ready=0 during SHIFT/DONE, second accept at edge N+DATA_W+2. Changing pattern mid-word must not alter the result.
- Reset abort: drop rst_ after shift 3 of a word. Required: no done pulse, all outputs at reset values, in_ready=1. The next word scans from empty history.
